// File: rtl/bus_exerciser.sv
// 6502-style bus initiator: writes a seeded pattern over an address window,
// reads it back through a synchronous responder and reports the comparison result.
module bus_exerciser #(
    parameter int RD_LAT = 1,
    parameter int LED_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      base,
    input  logic [15:0]      len,
    input  logic [7:0]       seed,
    output logic [15:0]      AB,
    output logic [7:0]       DO,
    output logic             WE,
    input  logic [7:0]       DI,
    input  logic             RDY,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [15:0]      fail_addr,
    output logic [LED_W-1:0] led
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_WAIT,
        RD_CHK,
        FIN
    } state_t;

    // With RD_LAT=0 the address cycle is itself the capture cycle, so reads start in RD_CHK.
    localparam state_t     READ_ENTRY = (RD_LAT == 0) ? RD_CHK : RD_ADDR;
    localparam state_t     AFTER_ADDR = (RD_LAT > 1) ? RD_WAIT : RD_CHK;
    localparam logic [1:0] WAIT_INIT  = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t      state;
    logic [15:0] base_q;
    logic [15:0] len_q;
    logic [7:0]  seed_q;
    logic [15:0] cur_addr;
    logic [15:0] remain;
    logic [1:0]  wait_cnt;

    function automatic logic [7:0] pattern(input logic [15:0] a, input logic [7:0] s);
        return a[7:0] ^ a[15:8] ^ s;
    endfunction

    logic        mismatch;
    logic [7:0]  err_next;
    logic [15:0] next_addr;

    always_comb begin
        mismatch  = (DI != pattern(cur_addr, seed_q));
        err_next  = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
        next_addr = cur_addr + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            cur_addr  <= '0;
            remain    <= '0;
            wait_cnt  <= '0;
            AB        <= '0;
            DO        <= '0;
            WE        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base;
                        len_q     <= len;
                        seed_q    <= seed;
                        cur_addr  <= base;
                        remain    <= len;
                        err_count <= '0;
                        fail_addr <= '0;
                        if (len == 16'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                            AB    <= '0;
                            WE    <= 1'b0;
                        end else begin
                            state <= WRITE;
                            busy  <= 1'b1;
                            pass  <= 1'b0;
                            AB    <= base;
                            DO    <= pattern(base, seed);
                            WE    <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (RDY) begin
                        if (remain == 16'd1) begin
                            WE       <= 1'b0;
                            AB       <= base_q;
                            cur_addr <= base_q;
                            remain   <= len_q;
                            state    <= READ_ENTRY;
                        end else begin
                            AB       <= next_addr;
                            DO       <= pattern(next_addr, seed_q);
                            cur_addr <= next_addr;
                            remain   <= remain - 16'd1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (RDY) begin
                        state    <= AFTER_ADDR;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                RD_WAIT: begin
                    if (RDY) begin
                        if (wait_cnt == 2'd0) begin
                            state <= RD_CHK;
                        end else begin
                            wait_cnt <= wait_cnt - 2'd1;
                        end
                    end
                end
                RD_CHK: begin
                    if (RDY) begin
                        err_count <= err_next;
                        if (mismatch && (err_count == 8'd0)) begin
                            fail_addr <= cur_addr;
                        end
                        // The done pulse is raised on entry so FIN is exactly the done cycle.
                        if (remain == 16'd1) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_next == 8'd0);
                            AB    <= '0;
                            WE    <= 1'b0;
                        end else begin
                            AB       <= next_addr;
                            cur_addr <= next_addr;
                            remain   <= remain - 16'd1;
                            state    <= READ_ENTRY;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // LED shows the result summary when idle, and write/read phase plus low address bits while running.
    always_comb begin
        if (busy) begin
            led = {1'b0, (state == WRITE), cur_addr[LED_W-3:0]};
        end else begin
            led = {pass, err_count[LED_W-2:0]};
        end
    end

endmodule

// File: tb/tb_bus_exerciser.sv
// Directed bench for bus_exerciser: a registered 64 KB responder with optional
// fault injection and RDY stretching, plus write/read address logging.
module tb_bus_exerciser;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] base;
    logic [15:0] len;
    logic [7:0]  seed;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        RDY;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;
    logic [15:0] fail_addr;
    logic [5:0]  led;

    int checks = 0;
    int errors = 0;

    logic        stuck_mode = 1'b0;
    logic        zero_mode  = 1'b0;
    logic        stall_mode = 1'b0;
    int          wr_seen = 0;
    int          rd_seen = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [15:0] rd_addr_q [$];

    logic        last_rdy  = 1'b1;
    logic        prev_busy = 1'b0;
    logic [15:0] prev_ab   = '0;
    logic [7:0]  prev_do   = '0;
    logic        prev_we   = 1'b0;

    bus_exerciser #(.RD_LAT(1), .LED_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .len       (len),
        .seed      (seed),
        .AB        (AB),
        .DO        (DO),
        .WE        (WE),
        .DI        (DI),
        .RDY       (RDY),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .led       (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] pat(input logic [15:0] a, input logic [7:0] s);
        return a[7:0] ^ a[15:8] ^ s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Registered responder: write on WE&&RDY, read data appears one edge after the address.
    always @(posedge clk) begin
        if (WE && RDY) mem[AB] <= DO;
        if (zero_mode) DI <= 8'h00;
        else if (stuck_mode && AB == 16'h0205) DI <= mem[AB] & 8'hF7;
        else DI <= mem[AB];
    end

    // Mid-cycle: check bus hold after a stalled edge, choose RDY for the next edge, log bus cycles.
    always @(negedge clk) begin
        logic rdy_next;
        if (!last_rdy && prev_busy && busy) begin
            checkOutput("hold_ab", AB, prev_ab);
            checkOutput("hold_do", DO, prev_do);
            checkOutput("hold_we", WE, prev_we);
        end
        rdy_next = 1'b1;
        if (stall_mode && busy) begin
            if (WE && AB == 16'h0203) begin
                wr_seen++;
                if (wr_seen <= 3) rdy_next = 1'b0;
            end
            if (!WE && AB == 16'h0207) begin
                rd_seen++;
                if (rd_seen >= 2 && rd_seen <= 4) rdy_next = 1'b0;
            end
        end
        RDY = rdy_next;
        if (busy && WE && RDY) begin
            wr_addr_q.push_back(AB);
            wr_data_q.push_back(DO);
        end
        if (busy && !WE && (rd_addr_q.size() == 0 || AB != rd_addr_q[rd_addr_q.size()-1]))
            rd_addr_q.push_back(AB);
        last_rdy  = RDY;
        prev_busy = busy;
        prev_ab   = AB;
        prev_do   = DO;
        prev_we   = WE;
    end

    task automatic applyStimulus(input logic [15:0] b, input logic [15:0] l, input logic [7:0] s);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        wr_seen = 0;
        rd_seen = 0;
        @(posedge clk);
        #1;
        base  = b;
        len   = l;
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (!done && lat < 4000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkAfterDone(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        logic [15:0] wrap_addr [4];
        logic [7:0]  wrap_data [4];
        wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        wrap_data = '{8'h32, 8'h33, 8'h33, 8'h32};

        reset = 1'b0;
        start = 1'b0;
        base  = '0;
        len   = '0;
        seed  = '0;
        RDY   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ab", AB, 16'h0);
        checkOutput("rst_do", DO, 8'h0);
        checkOutput("rst_we", WE, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_pass", pass, 1'b0);
        checkOutput("rst_err", err_count, 8'h0);
        checkOutput("rst_fail", fail_addr, 16'h0);
        checkOutput("rst_led", led, 6'h0);
        reset = 1'b1;

        // Clean run with an ignored start pulse while busy.
        applyStimulus(16'h0200, 16'd16, 8'h5A);
        checkOutput("clean_busy", busy, 1'b1);
        checkOutput("clean_first_do", DO, 8'h58);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        base  = 16'h1234;
        len   = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat);
        checkOutput("clean_lat", lat + 6, 48);
        checkOutput("clean_pass", pass, 1'b1);
        checkOutput("clean_err", err_count, 8'd0);
        checkOutput("clean_busy_done", busy, 1'b0);
        checkOutput("clean_led", led, 6'h20);
        checkOutput("clean_nwr", wr_addr_q.size(), 16);
        checkOutput("clean_nrd", rd_addr_q.size(), 16);
        for (int i = 0; i < 16 && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
            checkOutput("clean_wr_addr", wr_addr_q[i], 16'h0200 + 16'(i));
            checkOutput("clean_wr_data", wr_data_q[i], pat(16'h0200 + 16'(i), 8'h5A));
            checkOutput("clean_rd_addr", rd_addr_q[i], 16'h0200 + 16'(i));
        end
        checkAfterDone("clean");

        // Stuck bit 3 low at 0x0205 on reads only.
        stuck_mode = 1'b1;
        applyStimulus(16'h0200, 16'd16, 8'h5A);
        waitDone(lat);
        checkOutput("stuck_lat", lat, 48);
        checkOutput("stuck_pass", pass, 1'b0);
        checkOutput("stuck_err", err_count, 8'd1);
        checkOutput("stuck_fail", fail_addr, 16'h0205);
        checkOutput("stuck_led", led, 6'h01);
        stuck_mode = 1'b0;

        // Window crossing FFFF.
        applyStimulus(16'hFFFE, 16'd4, 8'h33);
        waitDone(lat);
        checkOutput("wrap_lat", lat, 12);
        checkOutput("wrap_pass", pass, 1'b1);
        checkOutput("wrap_nwr", wr_addr_q.size(), 4);
        checkOutput("wrap_nrd", rd_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
            checkOutput("wrap_wr_addr", wr_addr_q[i], wrap_addr[i]);
            checkOutput("wrap_wr_data", wr_data_q[i], wrap_data[i]);
            checkOutput("wrap_rd_addr", rd_addr_q[i], wrap_addr[i]);
        end

        // RDY stretched 3 cycles on write 0x0203 and read capture of 0x0207.
        stall_mode = 1'b1;
        applyStimulus(16'h0200, 16'd16, 8'h5A);
        waitDone(lat);
        checkOutput("stall_lat", lat, 54);
        checkOutput("stall_pass", pass, 1'b1);
        checkOutput("stall_nwr", wr_addr_q.size(), 16);
        checkOutput("stall_nrd", rd_addr_q.size(), 16);
        checkOutput("stall_wr_seen", wr_seen, 4);
        checkOutput("stall_rd_seen", rd_seen, 5);
        stall_mode = 1'b0;

        // Empty window.
        applyStimulus(16'h0300, 16'd0, 8'h11);
        checkOutput("empty_done", done, 1'b1);
        checkOutput("empty_pass", pass, 1'b1);
        checkOutput("empty_busy", busy, 1'b0);
        checkAfterDone("empty");
        checkOutput("empty_nwr", wr_addr_q.size(), 0);

        // All-zero responder: error counter saturates.
        zero_mode = 1'b1;
        applyStimulus(16'h0200, 16'd300, 8'h5A);
        waitDone(lat);
        checkOutput("zero_lat", lat, 900);
        checkOutput("zero_pass", pass, 1'b0);
        checkOutput("zero_err", err_count, 8'd255);
        checkOutput("zero_fail", fail_addr, 16'h0200);
        checkOutput("zero_led", led, 6'h1F);
        zero_mode = 1'b0;

        // Reset during the read phase, then a normal run.
        applyStimulus(16'h0200, 16'd16, 8'h5A);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #3;
        reset = 1'b0;
        #1;
        checkOutput("abort_ab", AB, 16'h0);
        checkOutput("abort_we", WE, 1'b0);
        checkOutput("abort_do", DO, 8'h0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_err", err_count, 8'h0);
        checkOutput("abort_led", led, 6'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("abort_done", done, 1'b0);
        end
        reset = 1'b1;
        applyStimulus(16'h0200, 16'd16, 8'h5A);
        waitDone(lat);
        checkOutput("rerun_lat", lat, 48);
        checkOutput("rerun_pass", pass, 1'b1);
        checkOutput("rerun_err", err_count, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
